// File: rtl/sound_decoder.sv
// Classifies 1-bit square-wave sound bursts into tick/eat/success/failure
// events by timing half-periods against a tick timebase and gaps against frames.
module sound_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_pulse,
  input  logic       pwm_base,
  input  logic       audio,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  output logic [3:0] ev_est,
  output logic       busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state_q, state_d;
  logic       vsync_q, pwm_q, audio_q;
  logic [4:0] tickCnt_q, tickCnt_d;
  logic [2:0] quiet_q, quiet_d;
  logic [3:0] firstEst_q, firstEst_d;
  logic       firstValid_q, firstValid_d;
  logic       rampSeen_q, rampSeen_d;
  logic       gapSeen_q, gapSeen_d;
  logic       edgeInFrame_q, edgeInFrame_d;
  logic       evValid_q, evValid_d;
  logic [1:0] evCode_q, evCode_d;
  logic [3:0] evEst_q, evEst_d;

  logic       frameEdge, tickEdge, audioEdge, edgeSeen, measValid;
  logic [4:0] cntMinus1;
  logic [3:0] measEst;
  logic [1:0] burstClass;

  assign frameEdge = vsync_pulse & ~vsync_q;
  assign tickEdge  = pwm_base & ~pwm_q;
  assign audioEdge = audio ^ audio_q;
  // An audio edge coincident with a frame edge belongs to the frame that is ending.
  assign edgeSeen  = edgeInFrame_q | audioEdge;
  assign measValid = (tickCnt_q != 5'd0) && (tickCnt_q <= 5'd16);
  assign cntMinus1 = tickCnt_q - 5'd1;
  assign measEst   = cntMinus1[3:0];

  always_comb begin
    burstClass = 2'd0;
    if (gapSeen_q) begin
      burstClass = (firstEst_q >= 4'd7) ? 2'd3 : 2'd2;
    end else if (rampSeen_q) begin
      burstClass = 2'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    tickCnt_d     = tickCnt_q;
    quiet_d       = quiet_q;
    firstEst_d    = firstEst_q;
    firstValid_d  = firstValid_q;
    rampSeen_d    = rampSeen_q;
    gapSeen_d     = gapSeen_q;
    edgeInFrame_d = edgeInFrame_q;
    evValid_d     = 1'b0;
    evCode_d      = evCode_q;
    evEst_d       = evEst_q;

    if (audioEdge) begin
      tickCnt_d = 5'd0;
    end else if (tickEdge && (tickCnt_q != 5'd31)) begin
      tickCnt_d = tickCnt_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        // Edges during the emitting cycle are swallowed, not burst starts.
        if (audioEdge && !evValid_q) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (audioEdge && measValid) begin
          if (!firstValid_q) begin
            firstEst_d   = measEst;
            firstValid_d = 1'b1;
          end else if (measEst != firstEst_q) begin
            rampSeen_d = 1'b1;
          end
        end
        if (frameEdge) begin
          edgeInFrame_d = 1'b0;
          if (edgeSeen) begin
            if (quiet_q >= 3'd2) begin
              gapSeen_d = 1'b1;
            end
            quiet_d = 3'd0;
          end else if (quiet_q == 3'd5) begin
            evValid_d     = 1'b1;
            evCode_d      = burstClass;
            evEst_d       = firstValid_q ? firstEst_q : 4'd0;
            state_d       = IDLE;
            tickCnt_d     = 5'd0;
            quiet_d       = 3'd0;
            firstEst_d    = 4'd0;
            firstValid_d  = 1'b0;
            rampSeen_d    = 1'b0;
            gapSeen_d     = 1'b0;
          end else begin
            quiet_d = quiet_q + 3'd1;
          end
        end else if (audioEdge) begin
          edgeInFrame_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      vsync_q       <= 1'b0;
      pwm_q         <= 1'b0;
      audio_q       <= 1'b0;
      tickCnt_q     <= 5'd0;
      quiet_q       <= 3'd0;
      firstEst_q    <= 4'd0;
      firstValid_q  <= 1'b0;
      rampSeen_q    <= 1'b0;
      gapSeen_q     <= 1'b0;
      edgeInFrame_q <= 1'b0;
      evValid_q     <= 1'b0;
      evCode_q      <= 2'd0;
      evEst_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync_pulse;
      pwm_q         <= pwm_base;
      audio_q       <= audio;
      tickCnt_q     <= tickCnt_d;
      quiet_q       <= quiet_d;
      firstEst_q    <= firstEst_d;
      firstValid_q  <= firstValid_d;
      rampSeen_q    <= rampSeen_d;
      gapSeen_q     <= gapSeen_d;
      edgeInFrame_q <= edgeInFrame_d;
      evValid_q     <= evValid_d;
      evCode_q      <= evCode_d;
      evEst_q       <= evEst_d;
    end
  end

  assign ev_valid = evValid_q;
  assign ev_code  = evCode_q;
  assign ev_est   = evEst_q;
  assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_sound_decoder.sv
// Directed bench for sound_decoder: table of synthesized bursts with
// hand-computed class/estimate, plus sequences for reset and edge-timing cases.
module tb_sound_decoder;

  logic       clk;
  logic       rst;
  logic       vsync_pulse;
  logic       pwm_base;
  logic       audio;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic [3:0] ev_est;
  logic       busy;

  logic aud;
  int   compares;
  int   failures;
  int   evCount;
  int   lastCode;
  int   lastEst;

  typedef struct {
    int    hp;
    bit    ramp;
    bit    gap;
    int    expCode;
    int    expEst;
    string name;
  } vec_t;

  vec_t vecs[10];

  sound_decoder dut (
    .clk(clk),
    .rst(rst),
    .vsync_pulse(vsync_pulse),
    .pwm_base(pwm_base),
    .audio(audio),
    .ev_valid(ev_valid),
    .ev_code(ev_code),
    .ev_est(ev_est),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard of emitted events, sampled mid-cycle.
  always @(negedge clk) begin
    if (ev_valid === 1'b1) begin
      evCount  = evCount + 1;
      lastCode = int'(ev_code);
      lastEst  = int'(ev_est);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compares = compares + 1;
    if (actual != expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic p);
    vsync_pulse = v;
    pwm_base    = p;
    audio       = aud;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic toggle();
    aud = ~aud;
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic frame();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic halfPeriod(input int n);
    repeat (n) tick();
    toggle();
  endtask

  task automatic finishBurst(input int startCount, input int expCode, input int expEst, input string name);
    repeat (5) frame();
    checkOutput({name, "/no_early_event"}, evCount, startCount);
    checkOutput({name, "/busy_before_end"}, int'(busy), 1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput({name, "/event_count"}, evCount, startCount + 1);
    checkOutput({name, "/code"}, lastCode, expCode);
    checkOutput({name, "/est"}, lastEst, expEst);
    checkOutput({name, "/busy_after"}, int'(busy), 0);
  endtask

  task automatic runBurst(input int hp, input bit ramp, input bit gap,
                          input int expCode, input int expEst, input string name);
    int startCount;
    int h;
    startCount = evCount;
    toggle();
    checkOutput({name, "/busy_start"}, int'(busy), 1);
    for (int f = 0; f < 4; f++) begin
      h = (ramp && (f == 1 || f == 2)) ? hp + 1 : hp;
      halfPeriod(h);
      halfPeriod(h);
      frame();
      if (gap && f == 1) repeat (3) frame();
    end
    finishBurst(startCount, expCode, expEst, name);
  endtask

  initial begin
    int startCount;
    compares = 0;
    failures = 0;
    evCount  = 0;
    lastCode = 0;
    lastEst  = 0;
    aud = 1'b0;
    vsync_pulse = 1'b0;
    pwm_base = 1'b0;
    audio = 1'b0;

    vecs[0] = '{6,  1'b0, 1'b0, 0, 5,  "tick_hp6"};
    vecs[1] = '{4,  1'b1, 1'b0, 1, 3,  "eat_hp4"};
    vecs[2] = '{10, 1'b0, 1'b1, 3, 9,  "fail_hp10"};
    vecs[3] = '{4,  1'b0, 1'b1, 2, 3,  "success_hp4"};
    vecs[4] = '{8,  1'b0, 1'b1, 3, 7,  "fail_est7"};
    vecs[5] = '{7,  1'b0, 1'b1, 2, 6,  "success_est6"};
    vecs[6] = '{16, 1'b0, 1'b0, 0, 15, "tick_cnt16"};
    vecs[7] = '{1,  1'b1, 1'b0, 1, 0,  "eat_cnt1"};
    vecs[8] = '{17, 1'b0, 1'b0, 0, 0,  "no_valid_est"};
    vecs[9] = '{17, 1'b0, 1'b1, 2, 0,  "gap_no_est"};

    rst = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("reset/ev_valid", int'(ev_valid), 0);
    checkOutput("reset/ev_code", int'(ev_code), 0);
    checkOutput("reset/ev_est", int'(ev_est), 0);
    checkOutput("reset/busy", int'(busy), 0);
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0);
    checkOutput("idle/busy", int'(busy), 0);

    for (int i = 0; i < 10; i++) begin
      runBurst(vecs[i].hp, vecs[i].ramp, vecs[i].gap, vecs[i].expCode, vecs[i].expEst, vecs[i].name);
    end

    // Audio edge on the same cycle as the frame edge counts for the ending frame.
    startCount = evCount;
    toggle();
    halfPeriod(6);
    aud = ~aud;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    frame();
    halfPeriod(6);
    frame();
    finishBurst(startCount, 0, 5, "coincident_edge");

    // A 40-tick gap between edges must be discarded as a measurement.
    startCount = evCount;
    toggle();
    halfPeriod(6);
    halfPeriod(6);
    frame();
    halfPeriod(40);
    halfPeriod(6);
    frame();
    finishBurst(startCount, 0, 5, "long_gap");

    // Reset mid-burst after a non-zero event: no event, outputs cleared.
    runBurst(10, 1'b0, 1'b1, 3, 9, "pre_reset_fail");
    startCount = evCount;
    toggle();
    halfPeriod(4);
    halfPeriod(4);
    frame();
    halfPeriod(5);
    rst = 1'b1;
    aud = 1'b0;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("mid_reset/busy", int'(busy), 0);
    checkOutput("mid_reset/ev_code", int'(ev_code), 0);
    checkOutput("mid_reset/ev_est", int'(ev_est), 0);
    repeat (8) frame();
    checkOutput("mid_reset/no_event", evCount, startCount);
    checkOutput("mid_reset/still_idle", int'(busy), 0);
    runBurst(6, 1'b0, 1'b0, 0, 5, "after_reset_tick");

    // An audio edge in the emitting cycle must not start a new burst.
    startCount = evCount;
    toggle();
    halfPeriod(6);
    halfPeriod(6);
    frame();
    repeat (5) frame();
    applyStimulus(1'b1, 1'b0);
    aud = ~aud;
    applyStimulus(1'b0, 1'b0);
    checkOutput("emit_edge/event_count", evCount, startCount + 1);
    checkOutput("emit_edge/code", lastCode, 0);
    checkOutput("emit_edge/busy", int'(busy), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("emit_edge/busy_later", int'(busy), 0);
    runBurst(6, 1'b0, 1'b0, 0, 5, "after_emit_edge");

    $display("End of test - %0d assertions evaluated, %0d failures", compares, failures);
    $finish;
  end

endmodule
